// File: rtl/embcpu_pio_in.sv
// Input PIO slave: synchronizes in_port, latches per-bit edges into a
// write-1-to-clear capture register and raises a maskable level irq.
module embcpu_pio_in #(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int PRIME_MAX = SYNC_STAGES + 1;
   localparam int PW        = $clog2(PRIME_MAX + 1);
   localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_MAX);

   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] clr;
   logic [PW-1:0]    prime_cnt;
   logic             primed;
   logic             wr;
   logic             wr_mask;
   logic             wr_cap;

   assign sync_q = sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++)
            sync_r[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_r[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_r[i] <= sync_r[i-1];
         prev_q <= sync_q;
      end
   end

   // Levels present at reset release must never look like edges, so
   // detection stays off until the whole chain and prev_q hold real data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         prime_cnt <= '0;
      else if (prime_cnt != PRIME_DONE)
         prime_cnt <= prime_cnt + 1'b1;
   end

   assign primed = (prime_cnt == PRIME_DONE);
   assign rise   = sync_q & ~prev_q;
   assign fall   = ~sync_q & prev_q;

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = primed ? rise : '0;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = primed ? fall : '0;
      end else begin : g_any
         assign edge_det = primed ? (rise | fall) : '0;
      end
   endgenerate

   assign wr      = chipselect & ~write_n;
   assign wr_mask = wr & (address == 3'd2);
   assign wr_cap  = wr & (address == 3'd3);
   assign clr     = wr_cap ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr_mask)
            irq_mask <= writedata[WIDTH-1:0];
         edge_cap <= (edge_cap & ~clr) | edge_det;
      end
   end

   assign irq = |(edge_cap & irq_mask);

   always_comb begin
      readdata = '0;
      case (address)
         3'd0: readdata[WIDTH-1:0] = sync_q;
         3'd2: readdata[WIDTH-1:0] = irq_mask;
         3'd3: readdata[WIDTH-1:0] = edge_cap;
         default: ;
      endcase
   end

   generate
      if (WIDTH < 32) begin : g_unused
         logic unused_wd;
         assign unused_wd = ^writedata[31:WIDTH];
      end
   endgenerate

endmodule

// File: tb/tb_embcpu_pio_in.sv
// Bench for embcpu_pio_in: rising-edge and any-edge instances share one
// bus; a history-based model feeds a scoreboard checked by a monitor.
module tb_embcpu_pio_in;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [7:0]  in_port = 8'hFF;
   logic [31:0] rd0, rd2;
   logic        irq0, irq2;

   always #5 clk = ~clk;

   embcpu_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   embcpu_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address),
      .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port),
      .readdata(rd2), .irq(irq2));

   typedef struct {
      logic [31:0] rd0;
      logic [31:0] rd2;
      logic        irq0;
      logic        irq2;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: hist[k] is the in_port value sampled k edges ago.
   logic [7:0] hist [S+1];
   logic [7:0] m_mask, m_cap0, m_cap2;
   int         edges_seen;
   string      cur_tag = "init";

   function automatic void model_reset();
      for (int i = 0; i <= S; i++) hist[i] = 8'h00;
      m_mask = '0;
      m_cap0 = '0;
      m_cap2 = '0;
      edges_seen = 0;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] a,
                                            input logic [7:0] cap);
      case (a)
         3'd0: return {24'h0, hist[S-1]};
         3'd2: return {24'h0, m_mask};
         3'd3: return {24'h0, cap};
         default: return 32'h0;
      endcase
   endfunction

   function automatic void check(input string tag, input exp_t e);
      n_tests++;
      if (rd0 !== e.rd0 || rd2 !== e.rd2 ||
          irq0 !== e.irq0 || irq2 !== e.irq2) begin
         n_fail++;
         $display("FAIL %s: got rd0=%h rd2=%h irq0=%b irq2=%b, want rd0=%h rd2=%h irq0=%b irq2=%b",
                  tag, rd0, rd2, irq0, irq2,
                  e.rd0, e.rd2, e.irq0, e.irq2);
      end
   endfunction

   // One bus cycle, entered and left at a falling edge.
   task automatic cyc(input logic [2:0] a, input logic cs,
                      input logic wn, input logic [31:0] wd,
                      input logic [7:0] inp);
      logic [7:0] s, p, clrm;
      logic       w;
      exp_t       e;
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      in_port    = inp;
      s = hist[S-1];
      p = hist[S];
      w = cs & ~wn;
      clrm = (w && a == 3'd3) ? wd[7:0] : 8'h00;
      if (edges_seen >= S + 1) begin
         m_cap0 = (m_cap0 & ~clrm) | (s & ~p);
         m_cap2 = (m_cap2 & ~clrm) | (s ^ p);
      end else begin
         m_cap0 = m_cap0 & ~clrm;
         m_cap2 = m_cap2 & ~clrm;
      end
      if (w && a == 3'd2) m_mask = wd[7:0];
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = inp;
      edges_seen++;
      e.rd0  = model_rd(a, m_cap0);
      e.rd2  = model_rd(a, m_cap2);
      e.irq0 = |(m_cap0 & m_mask);
      e.irq2 = |(m_cap2 & m_mask);
      e.tag  = cur_tag;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] inp);
      cyc(a, 1'b1, 1'b1, $urandom, inp);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d,
                     input logic [7:0] inp);
      cyc(a, 1'b1, 1'b0, d, inp);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, e);
      end
   end

   task automatic mid_reset(input logic [2:0] a);
      exp_t e;
      address    = a;
      chipselect = 1'b0;
      write_n    = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      e.rd0 = 32'h0; e.rd2 = 32'h0;
      e.irq0 = 1'b0; e.irq2 = 1'b0;
      check("async_reset", e);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0] v;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      cur_tag = "t1_prime";
      for (int i = 0; i < 5; i++) rd(3'd3, 8'hFF);
      for (int i = 0; i < 5; i++) rd(3'd0, 8'hFF);

      cur_tag = "t2_rise";
      rd(3'd0, 8'h00);
      for (int i = 0; i < 3; i++) rd(3'd0, 8'h00);
      wr(3'd3, 32'hFF, 8'h00);
      wr(3'd2, 32'h01, 8'h00);
      for (int i = 0; i < 3; i++) rd(3'd0, 8'h01);
      for (int i = 0; i < 2; i++) rd(3'd3, 8'h01);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h00);

      cur_tag = "t3_w1c";
      wr(3'd3, 32'h01, 8'h00);
      rd(3'd3, 8'h00);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h05);
      wr(3'd3, 32'hFF, 8'h05);
      rd(3'd3, 8'h00);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h05);
      wr(3'd3, 32'h00, 8'h05);
      rd(3'd3, 8'h05);

      cur_tag = "t4_set_wins";
      rd(3'd3, 8'h01);
      rd(3'd3, 8'h01);
      rd(3'd3, 8'h05);
      rd(3'd3, 8'h05);
      wr(3'd3, 32'h04, 8'h05);
      rd(3'd3, 8'h05);

      cur_tag = "t5_mask";
      wr(3'd2, 32'h00, 8'h05);
      wr(3'd3, 32'hFF, 8'h00);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h80);
      rd(3'd3, 8'h80);
      wr(3'd2, 32'h80, 8'h80);
      rd(3'd2, 8'h80);
      wr(3'd0, 32'hFF, 8'h80);
      rd(3'd0, 8'h80);
      rd(3'd5, 8'h80);
      wr(3'd3, 32'h80, 8'h80);
      rd(3'd3, 8'h80);

      cur_tag = "t6_any";
      wr(3'd2, 32'h08, 8'h00);
      wr(3'd3, 32'hFF, 8'h00);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h00);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h08);
      wr(3'd3, 32'h08, 8'h08);
      for (int i = 0; i < 4; i++) rd(3'd3, 8'h00);
      rd(3'd3, 8'h08);
      rd(3'd3, 8'h08);
      mid_reset(3'd3);
      for (int i = 0; i < 6; i++) rd(3'd3, 8'h08);

      cur_tag = "random";
      v = 8'h08;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0)
            v[$urandom_range(0, 7)] ^= 1'b1;
         cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, v);
         if (n == 200) mid_reset(3'd2);
      end

      repeat (3) @(posedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
